// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: FSM state type, encodings and sizing helper for
// the shift-and-add multiplier.
package seq_mult_pkg;

  localparam logic [2:0] ST_IDLE = 3'b001;
  localparam logic [2:0] ST_RUN  = 3'b010;
  localparam logic [2:0] ST_DONE = 3'b100;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_mult_if.sv
// seq_mult_if: start/done request bus of the sequential multiplier.
// is_signed exists only when SEQ_MULT_SIGNED_EN is defined.
interface seq_mult_if #(
  parameter int WIDTH = 8
);

  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
`ifdef SEQ_MULT_SIGNED_EN
  logic                 is_signed;
`endif
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

`ifdef SEQ_MULT_SIGNED_EN
  modport master (
    output start, a, b, is_signed,
    input  busy, done, product
  );
  modport slave (
    input  start, a, b, is_signed,
    output busy, done, product
  );
`else
  modport master (
    output start, a, b,
    input  busy, done, product
  );
  modport slave (
    input  start, a, b,
    output busy, done, product
  );
`endif

endinterface

// File: rtl/seq_mult_sign_adj.sv
// seq_mult_sign_adj: operand magnitudes at load and conditional
// negate of the finished product (two's-complement mode).
module seq_mult_sign_adj #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic               i_signed,
  input  logic [2*WIDTH-1:0] i_prod,
  input  logic               i_neg,
  output logic [WIDTH-1:0]   o_mag_a,
  output logic [WIDTH-1:0]   o_mag_b,
  output logic               o_neg,
  output logic [2*WIDTH-1:0] o_prod
);

  logic w_sa;
  logic w_sb;

  assign w_sa = i_signed & i_a[WIDTH-1];
  assign w_sb = i_signed & i_b[WIDTH-1];

  // -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude
  assign o_mag_a = w_sa ? -i_a : i_a;
  assign o_mag_b = w_sb ? -i_b : i_b;
  assign o_neg   = w_sa ^ w_sb;
  assign o_prod  = i_neg ? -i_prod : i_prod;

endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: one-bit-per-clock shift-and-add multiplier.
// Optional two's-complement mode via SEQ_MULT_SIGNED_EN.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  seq_mult_if.slave  bus
);

  import seq_mult_pkg::*;

  localparam int CW = cnt_w(WIDTH);

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_product;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_acc_nxt;
  logic [2*WIDTH-1:0]   w_prod_fin;
  logic [WIDTH-1:0]     w_ld_a;
  logic [WIDTH-1:0]     w_ld_b;
  logic                 w_accept;
  logic                 w_last;

  assign w_accept = bus.start & (r_state != RUN);
  assign w_last   = (r_state == RUN) &&
                    (r_cnt == CW'(WIDTH - 1));

  // upper half plus multiplicand keeps its carry, then shifts down
  assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                 (r_mplier[0] ? {1'b0, r_mcand} : '0);
  assign w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};

`ifdef SEQ_MULT_SIGNED_EN
  logic r_neg;
  logic w_ld_neg;

  seq_mult_sign_adj #(
    .WIDTH (WIDTH)
  ) u_sign_adj (
    .i_a      (bus.a),
    .i_b      (bus.b),
    .i_signed (bus.is_signed),
    .i_prod   (w_acc_nxt),
    .i_neg    (r_neg),
    .o_mag_a  (w_ld_a),
    .o_mag_b  (w_ld_b),
    .o_neg    (w_ld_neg),
    .o_prod   (w_prod_fin)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_neg <= 1'b0;
    else if (w_accept)
      r_neg <= w_ld_neg;
  end
`else
  assign w_ld_a     = bus.a;
  assign w_ld_b     = bus.b;
  assign w_prod_fin = w_acc_nxt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = bus.start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (r_state)
      RUN:     bus.busy = 1'b1;
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_mcand  <= w_ld_a;
      r_mplier <= w_ld_b;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == RUN) begin
      r_acc    <= w_acc_nxt;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last)
        r_product <= w_prod_fin;
    end
  end

  assign bus.product = r_product;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: WIDTH=4 directed and WIDTH=8 random checks
// against a plain-arithmetic reference multiply.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_mult_if #(.WIDTH(4)) m4 ();
  seq_mult_if #(.WIDTH(8)) m8 ();

  seq_multiplier #(.WIDTH(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (m4)
  );

  seq_multiplier #(.WIDTH(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (m8)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_mul(input int w, input int a,
                                          input int b, input bit s);
    int x;
    int y;
    int r;
    x = a;
    y = b;
    if (s && a >= (1 << (w - 1))) x = a - (1 << w);
    if (s && b >= (1 << (w - 1))) y = b - (1 << w);
    r = x * y;
    return 16'(r & ((1 << (2 * w)) - 1));
  endfunction

  task automatic mul4(input logic [3:0] a, input logic [3:0] b,
                      input bit s, input logic [7:0] exp,
                      input string tag_in);
    logic [7:0] prev;
    int lat;
    string tag;
    tag = s ? {tag_in, "_s"} : tag_in;
    @(negedge clk);
    prev = m4.product;
    m4.start = 1'b1;
    m4.a = a;
    m4.b = b;
`ifdef SEQ_MULT_SIGNED_EN
    m4.is_signed = s;
`endif
    @(posedge clk); #1;
    m4.start = 1'b0;
    m4.a = ~a;
    m4.b = ~b;
    lat = 0;
    while (m4.done !== 1'b1 && lat < 20) begin
      check({tag, "_busy"}, 32'(m4.busy), 32'd1);
      check({tag, "_hold"}, 32'(m4.product), 32'(prev));
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd4);
    check({tag, "_prod"}, 32'(m4.product), 32'(exp));
    check({tag, "_busy0"}, 32'(m4.busy), 32'd0);
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'(m4.done), 32'd0);
  endtask

  task automatic mul8(input logic [7:0] a, input logic [7:0] b,
                      input bit s, input string tag_in);
    logic [15:0] exp;
    int lat;
    string tag;
    tag = s ? {tag_in, "_s"} : tag_in;
    exp = ref_mul(8, int'(a), int'(b), s);
    @(negedge clk);
    m8.start = 1'b1;
    m8.a = a;
    m8.b = b;
`ifdef SEQ_MULT_SIGNED_EN
    m8.is_signed = s;
`endif
    @(posedge clk); #1;
    m8.start = 1'b0;
    m8.a = 8'($urandom);
    m8.b = 8'($urandom);
    lat = 0;
    while (m8.done !== 1'b1 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd8);
    check({tag, "_prod"}, 32'(m8.product), 32'(exp));
  endtask

  initial begin
    int nd;
    int t;
    int last;
    logic [7:0] pv;
    m4.start = 1'b0; m4.a = '0; m4.b = '0;
    m8.start = 1'b0; m8.a = '0; m8.b = '0;
`ifdef SEQ_MULT_SIGNED_EN
    m4.is_signed = 1'b0;
    m8.is_signed = 1'b0;
`endif

    #12;
    check("rst_busy4", 32'(m4.busy), 32'd0);
    check("rst_done4", 32'(m4.done), 32'd0);
    check("rst_prod4", 32'(m4.product), 32'd0);
    check("rst_busy8", 32'(m8.busy), 32'd0);
    check("rst_done8", 32'(m8.done), 32'd0);
    check("rst_prod8", 32'(m8.product), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    mul4(4'd1, 4'd0, 1'b0, 8'h00, "d1x0");
    mul4(4'd9, 4'd2, 1'b0, 8'h12, "d9x2");
    mul4(4'd13, 4'd4, 1'b0, 8'h34, "d13x4");
    mul4(4'd15, 4'd15, 1'b0, 8'hE1, "d15x15");

    // start pulsed during RUN must be ignored
    @(negedge clk);
    m4.start = 1'b1; m4.a = 4'd5; m4.b = 4'd3;
    @(negedge clk);
    m4.start = 1'b0;
    @(negedge clk);
    m4.start = 1'b1; m4.a = 4'd15; m4.b = 4'd15;
    @(negedge clk);
    m4.start = 1'b0;
    check("ign_busy", 32'(m4.busy), 32'd1);
    nd = 0;
    pv = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (m4.done === 1'b1) begin
        nd++;
        pv = m4.product;
      end
    end
    check("ign_ndone", 32'(nd), 32'd1);
    check("ign_prod", 32'(pv), 32'h0F);

    // start held high: one result every WIDTH+1 cycles
    @(negedge clk);
    m4.start = 1'b1; m4.a = 4'd6; m4.b = 4'd7;
    last = -1;
    nd = 0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      check("hold_busy", 32'(m4.busy), 32'(!m4.done));
      if (m4.done === 1'b1) begin
        check("hold_prod", 32'(m4.product), 32'h2A);
        if (last >= 0) check("hold_gap", 32'(i - last), 32'd5);
        last = i;
        nd++;
      end
    end
    check("hold_ndone", 32'(nd), 32'd4);
    m4.start = 1'b0;
    t = 0;
    while ((m4.busy === 1'b1 || m4.done === 1'b1) && t < 12) begin
      @(negedge clk);
      t++;
    end
    check("hold_idle", 32'(m4.busy), 32'd0);

    // asynchronous reset two cycles into RUN
    @(negedge clk);
    m4.start = 1'b1; m4.a = 4'd7; m4.b = 4'd7;
    @(posedge clk); #1;
    m4.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(m4.busy), 32'd0);
    check("arst_done", 32'(m4.done), 32'd0);
    check("arst_prod", 32'(m4.product), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (m4.done === 1'b1) nd++;
    end
    check("arst_nodone", 32'(nd), 32'd0);
    mul4(4'd7, 4'd7, 1'b0, 8'h31, "post_rst");

`ifdef SEQ_MULT_SIGNED_EN
    mul4(4'hD, 4'd5, 1'b1, 8'hF1, "sgn_m3x5");
    mul4(4'h8, 4'h8, 1'b1, 8'h40, "sgn_m8xm8");
    mul4(4'h8, 4'h8, 1'b0, 8'h40, "uns_8x8");
    mul8(8'h80, 8'h80, 1'b1, "c80x80");
    mul8(8'h80, 8'h01, 1'b1, "c80x01");
    mul8(8'hFF, 8'h7F, 1'b1, "cFFx7F");
`endif
    mul8(8'hFF, 8'hFF, 1'b0, "cFFxFF");
    mul8(8'h00, 8'hA5, 1'b0, "c00xA5");

    for (int i = 0; i < 40; i++) begin
      bit s;
`ifdef SEQ_MULT_SIGNED_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      mul8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           s, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised sequential shift-and-add multiplier for WIDTH-bit operands with a start/done handshake and a 2·WIDTH-bit registered product. One multiplier bit is processed per clock, trading the single-cycle combinational array for low area and a short critical path. Sits in the datapath as the general multiply unit; the WIDTH=4 instance is a drop-in replacement for the 4×4 combinational multiplier, with handshake added.

## Interface
- WIDTH, default 8: operand width in bits (≥2); product is 2·WIDTH bits.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when not busy.
- a  input  WIDTH  multiplicand, sampled with start.
- b  input  WIDTH  multiplier, sampled with start.
- is_signed  input  1  two's-complement mode select, sampled with start (present only with SEQ_MULT_SIGNED_EN).
- busy  output  1  high while a multiplication is in progress.
- done  output  1  one-cycle pulse: product valid.
- product  output  2·WIDTH  result register; holds until the next completion.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: busy=0. On start=1, latch a, b (and is_signed), clear accumulator and bit counter, go to RUN.
- RUN: busy=1. Each cycle: if current multiplier LSB=1, add the multiplicand to the upper accumulator half (WIDTH+1-bit sum keeps the carry); shift the accumulator right by one; counter++. After WIDTH RUN cycles, copy the accumulator to product and go to DONE.
- DONE: busy=0, done=1 for exactly one cycle. If start=1 in DONE, it is accepted as in IDLE (go straight to RUN); otherwise go to IDLE.
- start while busy=1 is ignored; latched operands are not disturbed. Input changes during RUN have no effect.
- Arithmetic: unsigned result = a·b exactly, with no overflow possible in 2·WIDTH bits.
- product changes only on entry to DONE; it is stable in all other cycles.
- Reset (any time, including mid-RUN): state=IDLE, busy=0, done=0, product=0, accumulator and counter=0; the in-flight operation is discarded and no done is produced.

## Timing
- start sampled high at edge k (IDLE or DONE): busy=1 after edge k.
- RUN occupies edges k+1 … k+WIDTH; after edge k+WIDTH: done=1, busy=0, product valid.
- Latency: WIDTH cycles from start sample to done. Back-to-back throughput: one result per WIDTH+1 cycles (start held high in DONE).
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- SEQ_MULT_SIGNED_EN defined: is_signed port exists. With is_signed=1, operands are converted to magnitudes at load, the unsigned core runs unchanged, and the product is two's-complement negated on entry to DONE when the operand signs differ. Latency is unchanged. The most negative value (−2^(WIDTH−1)) is handled exactly because magnitudes are kept in WIDTH bits unsigned.
- Macro undefined: no is_signed port; strictly unsigned.

## Structure
- Package seq_mult_pkg: state enum typedef (IDLE/RUN/DONE), state encoding constants, and a counter-width helper function (clog2 of WIDTH+1).
- One sub-module, seq_mult_sign_adj: combinational magnitude and conditional-negate helper, instantiated only under SEQ_MULT_SIGNED_EN.
- Counter, accumulator and FSM live in seq_multiplier.

## Test plan
- WIDTH=4, a=1, b=0 → done after 4 cycles, product=8'h00; a=9, b=2 → 8'h12; a=13, b=4 → 8'h34; a=15, b=15 → 8'hE1.
- WIDTH=4, a=5, b=3 started, then start pulsed with a=15, b=15 during RUN → exactly one done, product=8'h0F; busy=1 throughout RUN.
- Start held high continuously with fixed operands → done every 5 cycles, busy low only in DONE cycles, product constant.
- rst asserted asynchronously two cycles into RUN (a=7, b=7) → busy, done and product go to 0 immediately; no done follows; the next start completes normally with 8'h31.
- SEQ_MULT_SIGNED_EN, WIDTH=4, is_signed=1: a=4'hD (−3), b=5 → 8'hF1; a=4'h8, b=4'h8 (−8·−8) → 8'h40; is_signed=0 with the same operands → 8'h40 unsigned (8·8).
- Random WIDTH=8 sweep, both modes → product matches the reference multiply, with done latency exactly 8 cycles.
